// File: rtl/line_buffer.sv
// line_buffer: input stage for the CA1 datapath register.
// Collects DEPTH words from the file-reader stream, then serves one word per
// write_reg strobe at the address given by line_index (1-cycle read latency).
// Optional feature macro: LINE_PARITY_EN adds a stored even-parity bit per word
// and a sticky par_err output raised when a read word fails its parity check.
module line_buffer #(
  parameter int DATA_W = 25,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              load_done,
  output logic              full,
  input  logic [IDX_W-1:0]  line_index,
  input  logic              write_reg,
  output logic [DATA_W-1:0] line_data,
  output logic              line_valid,
  output logic              rd_err
`ifdef LINE_PARITY_EN
  ,
  output logic              par_err
`endif
);

`ifdef LINE_PARITY_EN
  localparam int MEM_W = DATA_W + 1;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_par(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   wr_ptr_q;
  logic [MEM_W-1:0]   mem_q [DEPTH];
  logic               load_done_q;
  logic [DATA_W-1:0]  line_data_q;
  logic               line_valid_q;
  logic               rd_err_q;
`ifdef LINE_PARITY_EN
  logic               par_err_q;
`endif

  logic               accept_s;
  logic               last_s;
  logic               full_s;
  logic [MEM_W-1:0]   rd_word_s;
  logic [MEM_W-1:0]   wr_word_s;

  // A word offered together with load_start is dropped: the load restarts instead.
  assign in_ready  = (state_q == ST_LOAD);
  assign accept_s  = in_valid & in_ready & ~load_start;
  assign last_s    = accept_s & (wr_ptr_q == IDX_W'(DEPTH - 1));
  assign full_s    = (state_q == ST_FULL);
  assign rd_word_s = mem_q[line_index];
`ifdef LINE_PARITY_EN
  assign wr_word_s = {even_par(in_data), in_data};
`else
  assign wr_word_s = in_data;
`endif

  assign full       = full_s;
  assign load_done  = load_done_q;
  assign line_data  = line_data_q;
  assign line_valid = line_valid_q;
  assign rd_err     = rd_err_q;
`ifdef LINE_PARITY_EN
  assign par_err    = par_err_q;
`endif

  // Buffer storage: written on accepted words only, never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && accept_s) begin
      mem_q[wr_ptr_q] <= wr_word_s;
    end
  end

  // Load FSM, write pointer and registered read port / status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      load_done_q  <= 1'b0;
      line_data_q  <= '0;
      line_valid_q <= 1'b0;
      rd_err_q     <= 1'b0;
`ifdef LINE_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      load_done_q  <= last_s;
      line_valid_q <= write_reg;

      // The read sees the state of this cycle, before any load_start takes effect.
      if (write_reg) begin
        if (full_s) begin
          line_data_q <= rd_word_s[DATA_W-1:0];
`ifdef LINE_PARITY_EN
          if (even_par(rd_word_s[DATA_W-1:0]) != rd_word_s[DATA_W]) begin
            par_err_q <= 1'b1;
          end
`endif
        end else begin
          line_data_q <= '0;
          rd_err_q    <= 1'b1;
        end
      end

      // load_start restarts from any state; its clears win over a same-cycle error.
      if (load_start) begin
        state_q  <= ST_LOAD;
        wr_ptr_q <= '0;
        rd_err_q <= 1'b0;
`ifdef LINE_PARITY_EN
        par_err_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_LOAD: begin
            if (accept_s) begin
              wr_ptr_q <= wr_ptr_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            if (last_s) begin
              state_q <= ST_FULL;
            end
          end
          ST_FULL: state_q <= ST_FULL;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/line_buffer.md
Name: line_buffer

Overview:
- Input stage feeding the CA1 datapath register.
- Collects DEPTH words from the upstream file-reader stream into an internal buffer.
- Once full, serves the word selected by the controller's 6-bit line_index, one word per write_reg pulse.
- Handshake on the input side and a done pulse back to the controller; registered read port toward the datapath.

Parameters:
- DATA_W, 25, width of one stored line word.
- DEPTH, 64, number of buffered words; must equal 2**IDX_W.
- IDX_W, 6, width of line_index and of the internal write pointer.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle pulse from the controller (read_file); (re)starts a load.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_W  upstream word.
- in_ready  output  1  buffer accepts a word this cycle.
- load_done  output  1  one-cycle pulse; all DEPTH words captured.
- full  output  1  level; buffer holds a complete, readable set.
- line_index  input  IDX_W  read address from the controller.
- write_reg  input  1  read strobe from the controller.
- line_data  output  DATA_W  registered read data.
- line_valid  output  1  one-cycle pulse, line_data updated.
- rd_err  output  1  sticky; a read was attempted while not full.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; wr_ptr=0.
  - in_ready=0, load_done=0, full=0, line_data=0, line_valid=0, rd_err=0.
  - Memory contents are not cleared.
  - Reset overrides every other input, including mid-load; the partial load is discarded.
- FSM states: IDLE, LOAD, FULL.
  - IDLE: in_ready=0. Goes to LOAD on load_start.
  - LOAD: in_ready=1 (combinational from state).
    - Accept when in_valid & in_ready: mem[wr_ptr] <= in_data, wr_ptr <= wr_ptr+1 (wraps to 0 mod DEPTH).
    - An accept at wr_ptr==DEPTH-1 moves to FULL; load_done=1 for exactly the next cycle.
  - FULL: in_ready=0, full=1. Stays in FULL until load_start.
- load_start in any state, including mid-LOAD:
  - Next state is LOAD, wr_ptr=0, full=0, rd_err=0.
  - A word offered in the same cycle is not accepted.
- Read path:
  - write_reg with state==FULL: line_data <= mem[line_index] at the edge, line_valid=1 the following cycle. Latency is 1 cycle.
  - write_reg with state!=FULL: line_data <= 0, line_valid=1, rd_err <= 1.
  - With no write_reg, line_data holds its value and line_valid=0.
  - Back-to-back write_reg on consecutive cycles is supported at one word per cycle.
- Simultaneous events:
  - write_reg and load_start in the same cycle: the read is evaluated against the current state; load_start then takes effect.
  - write_reg in the cycle the final word is accepted: counts as not full, so rd_err is set.
- Arithmetic: wr_ptr is IDX_W bits wide; no overflow is visible outside the block.

Optional Feature:
- Macro: LINE_PARITY_EN.
- When defined:
  - Each stored word carries an extra even-parity bit computed from in_data on accept.
  - On every FULL read, parity is recomputed on the read word.
  - A mismatch raises output par_err: sticky, reset by rst or load_start, registered in the same cycle as line_valid.
- When not defined: no extra storage, no par_err port; behaviour is otherwise identical.

Test Plan:
- rst, then pulse load_start, stream words 0..63 with in_data=index*3 and in_valid held high -> in_ready=1 for 64 cycles; load_done pulses exactly once, the cycle after word 63; full=1 and in_ready=0 afterwards.
- After a full load, write_reg with line_index=0, 17, 63 on consecutive cycles -> line_data=0, 51, 189 on the three cycles following each strobe; line_valid high for those 3 cycles.
- Upstream throttled (in_valid toggling 1,0,1,0...) during load -> only valid cycles are written; full reached after 64 accepted words (~127 cycles); read of index 5 returns 15.
- write_reg during LOAD after 10 words, line_index=3 -> line_data=0, line_valid=1, rd_err=1 and sticky; subsequent load_start clears rd_err to 0.
- Mid-load reset after 30 words, then a new load of 64 words with in_data=0x1000+index -> load_done appears only after 64 new accepts; index 0 reads 0x1000, index 63 reads 0x103F.
- (LINE_PARITY_EN) full load, force a bit flip in mem[7] via hierarchical access, read index 7 -> par_err=1; read of index 8 leaves par_err at 1 (sticky); load_start clears it.
